bitcoin_lane_sched: RTL and testbench

Controller for the parallel SHA-256 lane array of the bitcoin hash engine. It runs one job of one or more batches of `NUM_NONCES` nonces. For each job it issues the shared block-1 midstate pass once; for each batch it then issues the per-nonce block-2 pass and the hash-of-hash pass. It drives the lanes' round enables, nonce base and phase select, then streams each lane's final `h0` out through a req/ack write port.

---
 rtl/types_pkg.sv | 22 ++
 rtl/sched_round_ctr.sv | 25 ++
 rtl/bitcoin_lane_sched.sv | 164 ++++++++++++++++
 tb/tb_bitcoin_lane_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types and constants for the hash engine scheduler.
package types_pkg;

    localparam int num_nonces = 16;
    localparam int SHA_ROUNDS = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FOLD,
        WRITE,
        DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        P1 = 2'd0,
        P2 = 2'd1,
        P3 = 2'd2
    } sched_phase_t;

endpackage

// File: rtl/sched_round_ctr.sv
// SHA-256 round counter: clears on load, counts on en, flags the last round.
// Latency: count is a register, tc is decoded combinationally from it.
// Backpressure: none; wraps to 0 after the last round so it idles at 0.
module sched_round_ctr
    import types_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    output logic [5:0] cnt,
    output logic       tc
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 6'd1;
        end
    end

    assign tc = (cnt == 6'(SHA_ROUNDS - 1));

endmodule

// File: rtl/bitcoin_lane_sched.sv
// Lane-array scheduler: P1 once per job, then P2/P3/WRITE per batch of nonces.
// Latency: all outputs registered; first core_start one cycle after start.
// Backpressure: WRITE holds lane/addr until wr_ack; BITCOIN_SCHED_PERF_EN adds cycle_count.
module bitcoin_lane_sched
    import types_pkg::*;
#(
    parameter int NUM_NONCES = num_nonces,
    parameter int ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    cfg_batches,
    input  logic [31:0]                   cfg_nonce_start,
    output logic                          busy,
    output logic                          done,
    output logic                          core_start,
    output logic [1:0]                    core_phase,
    output logic                          round_en,
    output logic [5:0]                    round_idx,
    output logic                          core_fold,
    output logic [31:0]                   nonce_base,
    output logic                          wr_req,
    input  logic                          wr_ack,
    output logic [$clog2(NUM_NONCES)-1:0] wr_lane,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [31:0]                   cycle_count
);

    localparam int LW = $clog2(NUM_NONCES);
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_NONCES - 1);

    sched_state_t      state;
    sched_phase_t      phase;
    logic [7:0]        batches_q;
    logic [7:0]        batch_cnt;
    logic [ADDR_W-1:0] wcnt;
    logic              rnd_tc;

    sched_round_ctr u_round_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (state == LOAD),
        .en    (state == ROUND),
        .cnt   (round_idx),
        .tc    (rnd_tc)
    );

    // Phase reads back as P1 (0) outside passes, which is also the idle value.
    assign core_phase = phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= P1;
            batches_q  <= '0;
            batch_cnt  <= '0;
            wcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_start <= 1'b0;
            round_en   <= 1'b0;
            core_fold  <= 1'b0;
            nonce_base <= '0;
            wr_req     <= 1'b0;
            wr_lane    <= '0;
            wr_addr    <= '0;
        end else begin
            core_start <= 1'b0;
            core_fold  <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        batches_q  <= cfg_batches;
                        batch_cnt  <= '0;
                        wcnt       <= '0;
                        nonce_base <= cfg_nonce_start;
                        if (cfg_batches == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            core_start <= 1'b1;
                            phase      <= P1;
                        end
                    end
                end
                LOAD: begin
                    state    <= ROUND;
                    round_en <= 1'b1;
                end
                ROUND: begin
                    if (rnd_tc) begin
                        state     <= FOLD;
                        round_en  <= 1'b0;
                        core_fold <= 1'b1;
                    end
                end
                FOLD: begin
                    if (phase == P3) begin
                        state   <= WRITE;
                        phase   <= P1;
                        wr_req  <= 1'b1;
                        wr_lane <= '0;
                        wr_addr <= wcnt;
                    end else begin
                        state      <= LOAD;
                        core_start <= 1'b1;
                        phase      <= (phase == P1) ? P2 : P3;
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        wcnt <= wcnt + ADDR_W'(1);
                        if (wr_lane == LAST_LANE) begin
                            wr_req  <= 1'b0;
                            wr_lane <= '0;
                            wr_addr <= '0;
                            if (batch_cnt == batches_q - 8'd1) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                batch_cnt  <= batch_cnt + 8'd1;
                                nonce_base <= nonce_base + 32'(NUM_NONCES);
                                state      <= LOAD;
                                core_start <= 1'b1;
                                phase      <= P2;
                            end
                        end else begin
                            wr_lane <= wr_lane + LW'(1);
                            wr_addr <= wcnt + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BITCOIN_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state == IDLE && start) begin
            perf_q <= '0;
        end else if (busy) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign cycle_count = perf_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_bitcoin_lane_sched.sv
// Bench for bitcoin_lane_sched: table vectors, randomized jobs against a timeline model, reset corner.
module tb_bitcoin_lane_sched;

    localparam int N  = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    cfg_batches;
    logic [31:0]   cfg_nonce_start;
    logic          busy, done, core_start, round_en, core_fold, wr_req, wr_ack;
    logic [1:0]    core_phase;
    logic [5:0]    round_idx;
    logic [31:0]   nonce_base, cycle_count;
    logic [3:0]    wr_lane;
    logic [AW-1:0] wr_addr;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int k_stall[256];
    int acc_cyc[$];
    int cs_cyc[$];
    int cs_ph[$];
    int done_cyc;

    typedef struct {
        int          batches;
        logic [31:0] nonce;
        int          stall_idx;
        int          stall_len;
        int          exp_done_off;
    } vec_t;

    vec_t vt[5];

    bitcoin_lane_sched #(.NUM_NONCES(N), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_batches     (cfg_batches),
        .cfg_nonce_start (cfg_nonce_start),
        .busy            (busy),
        .done            (done),
        .core_start      (core_start),
        .core_phase      (core_phase),
        .round_en        (round_en),
        .round_idx       (round_idx),
        .core_fold       (core_fold),
        .nonce_base      (nonce_base),
        .wr_req          (wr_req),
        .wr_ack          (wr_ack),
        .wr_lane         (wr_lane),
        .wr_addr         (wr_addr),
        .cycle_count     (cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_phase"}, core_phase, 0);
        chk({tag, "_round_en"}, round_en, 0);
        chk({tag, "_round_idx"}, round_idx, 0);
        chk({tag, "_core_fold"}, core_fold, 0);
        chk({tag, "_nonce_base"}, nonce_base, 0);
        chk({tag, "_wr_req"}, wr_req, 0);
        chk({tag, "_wr_lane"}, wr_lane, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // Runs one job, logging events; expected timeline is rebuilt from pass/write arithmetic.
    task automatic run_job(input int B, input logic [31:0] ns, input bit noise, output int done_off);
        int          T, idx, stall, last_cs, rounds, folds, budget, sumk, c, cur, ai, w, acc, exp_done;
        bit          seen_done;
        logic [31:0] enb;
        acc_cyc.delete();
        cs_cyc.delete();
        cs_ph.delete();
        done_cyc = -1;
        idx = 0; stall = 0; last_cs = -1000; rounds = 0; folds = 0; sumk = 0;
        for (int i = 0; i < B * N; i++) sumk += k_stall[i];
        budget = 300 + B * 148 + sumk;
        @(negedge clk);
        chk("idle_busy_before_start", busy, 0);
        cfg_batches = 8'(B);
        cfg_nonce_start = ns;
        start = 1'b1;
        wr_ack = 1'b0;
        T = cyc;
        seen_done = 1'b0;
        for (int n = 0; n < budget && !seen_done; n++) begin
            @(negedge clk);
            c = cyc;
            chk("busy_during_job", busy, 1);
            if (core_start) begin
                cs_cyc.push_back(c);
                cs_ph.push_back(int'(core_phase));
                last_cs = c;
                if (core_phase == 2'd1) begin
                    enb = ns + 32'(((cs_cyc.size() - 2) / 2) * N);
                    chk("nonce_base_at_p2", nonce_base, enb);
                end
            end
            if (round_en) begin
                rounds++;
                chk("round_idx", round_idx, c - last_cs - 1);
            end
            if (core_fold) begin
                folds++;
                chk("fold_cycle", c, last_cs + 65);
            end
            if (wr_req) begin
                chk("wr_lane", wr_lane, idx % N);
                chk("wr_addr", wr_addr, idx % 65536);
                enb = ns + 32'((idx / N) * N);
                chk("wr_nonce_base", nonce_base, enb);
                if (stall < k_stall[idx]) begin
                    wr_ack = 1'b0;
                    stall++;
                end else begin
                    wr_ack = 1'b1;
                    acc_cyc.push_back(c);
                    idx++;
                    stall = 0;
                end
            end else begin
                wr_ack = 1'($urandom_range(0, 1));
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc = c;
            end
            start = (noise && !done) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (noise) begin
                cfg_batches = 8'($urandom);
                cfg_nonce_start = $urandom;
            end
        end
        chk("job_done_seen", seen_done, 1);
        chk("core_start_count", cs_cyc.size(), (B == 0) ? 0 : 1 + 2 * B);
        chk("write_count", acc_cyc.size(), B * N);
        chk("round_cycles", rounds, (B == 0) ? 0 : 64 * (1 + 2 * B));
        chk("fold_count", folds, (B == 0) ? 0 : 1 + 2 * B);
        if (B == 0) begin
            exp_done = T + 1;
        end else begin
            if (cs_cyc.size() > 0) begin
                chk("p1_start_cycle", cs_cyc[0], T + 1);
                chk("p1_phase", cs_ph[0], 0);
            end
            cur = T + 67;
            ai = 0;
            for (int b = 0; b < B; b++) begin
                if (cs_cyc.size() > 2 * b + 2) begin
                    chk("p2_start_cycle", cs_cyc[1 + 2 * b], cur);
                    chk("p2_phase", cs_ph[1 + 2 * b], 1);
                    chk("p3_start_cycle", cs_cyc[2 + 2 * b], cur + 66);
                    chk("p3_phase", cs_ph[2 + 2 * b], 2);
                end
                w = cur + 132;
                for (int l = 0; l < N; l++) begin
                    acc = w + k_stall[ai];
                    if (ai < acc_cyc.size()) chk("write_accept_cycle", acc_cyc[ai], acc);
                    w = acc + 1;
                    ai++;
                end
                cur = w;
            end
            exp_done = cur;
        end
        chk("done_cycle", done_cyc, exp_done);
        done_off = done_cyc - T;
        start = 1'b0;
        wr_ack = 1'b0;
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_single_pulse", done, 0);
        chk("wr_req_after_done", wr_req, 0);
    endtask

    initial begin
        int off, T, B;
        vt[0] = '{1, 32'h0000_0000, -1, 0, 215};
        vt[1] = '{2, 32'hFFFF_FFF8, -1, 0, 363};
        vt[2] = '{1, 32'h0000_0000, 3, 5, 220};
        vt[3] = '{0, 32'h0000_1234, -1, 0, 1};
        vt[4] = '{3, 32'h0000_0010, 20, 2, 513};

        reset = 1'b1;
        start = 1'b0;
        wr_ack = 1'b0;
        cfg_batches = 8'd0;
        cfg_nonce_start = 32'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 256; j++) k_stall[j] = 0;
            if (vt[i].stall_idx >= 0) k_stall[vt[i].stall_idx] = vt[i].stall_len;
            run_job(vt[i].batches, vt[i].nonce, 1'b0, off);
            chk("vec_done_offset", off, vt[i].exp_done_off);
            if (i == 0) begin
`ifdef BITCOIN_SCHED_PERF_EN
                chk("cycle_count_after_job", cycle_count, 215);
                repeat (10) @(negedge clk);
                chk("cycle_count_held", cycle_count, 215);
`else
                chk("cycle_count_tied", cycle_count, 0);
`endif
            end
        end

        // Reset in the middle of P2's rounds, then a clean restart.
        for (int j = 0; j < 256; j++) k_stall[j] = 0;
        @(negedge clk);
        cfg_batches = 8'd1;
        cfg_nonce_start = 32'h0000_0040;
        start = 1'b1;
        T = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (86) @(negedge clk);
        chk("mid_p2_round_en", round_en, 1);
        chk("mid_p2_phase", core_phase, 1);
        chk("mid_p2_offset", cyc - T, 87);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        run_job(1, 32'h0, 1'b0, off);
        chk("restart_done_offset", off, 215);

        for (int r = 0; r < 6; r++) begin
            B = $urandom_range(0, 3);
            for (int j = 0; j < 256; j++)
                k_stall[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_job(B, $urandom, 1'b1, off);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
